// File: rtl/ema_pkg.sv
// Shared widths, FSM state encoding and datapath control bundle for the EMA filter core.
package ema_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned SEL_W      = 8;
   localparam int unsigned COEF_W     = 16;
   localparam int unsigned ALPHA_FRAC = 6;

   localparam int unsigned DIFF_W     = DATA_W + 1;
   localparam int unsigned PROD_W     = DATA_W + 1 + ALPHA_FRAC + 1;
   localparam int unsigned ROUND_BIAS = 1 << (ALPHA_FRAC - 1);

   typedef enum logic [2:0] {
      IDLE,
      SUB,
      MUL,
      ACC,
      OUT
   } ema_state_t;

   typedef struct packed {
      logic load_x;
      logic sub_en;
      logic mul_en;
      logic acc_en;
   } ema_ctrl_t;

endpackage

// File: rtl/ema_step_dp.sv
// EMA step datapath: x/y registers, difference, coefficient multiply and shift back to sample scale.
// Optional round-half-up before the shift when EMA_ROUND_EN is defined.
module ema_step_dp
   import ema_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  ema_ctrl_t             ctrl,
   input  logic                  primed,
   input  logic [DATA_W-1:0]     s_data,
   input  logic [ALPHA_FRAC-1:0] coef,
   output logic [DATA_W-1:0]     y_acc_c
);

   logic signed [DATA_W-1:0] x_r;
   logic signed [DATA_W-1:0] y_r;
   logic [ALPHA_FRAC-1:0]    coef_r;
   logic signed [DIFF_W-1:0] diff_r;
   logic signed [PROD_W-1:0] prod_r;
   logic signed [PROD_W-1:0] prod_rnd;
   logic signed [PROD_W-1:0] sum;

   // Pipeline registers, one stage enabled per FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r    <= '0;
         y_r    <= '0;
         coef_r <= '0;
         diff_r <= '0;
         prod_r <= '0;
      end else begin
         if (ctrl.load_x) begin
            x_r <= s_data;
         end
         if (ctrl.sub_en) begin
            diff_r <= DIFF_W'(x_r) - DIFF_W'(y_r);
            coef_r <= coef;
         end
         if (ctrl.mul_en) begin
            prod_r <= PROD_W'(diff_r) * PROD_W'($signed({1'b0, coef_r}));
         end
         if (ctrl.acc_en) begin
            y_r <= y_acc_c;
         end
      end
   end

   // New y: first sample after priming loss is taken as-is
   always_comb begin
`ifdef EMA_ROUND_EN
      prod_rnd = prod_r + PROD_W'(ROUND_BIAS);
`else
      prod_rnd = prod_r;
`endif
      sum     = PROD_W'(y_r) + (prod_rnd >>> ALPHA_FRAC);
      y_acc_c = primed ? DATA_W'(sum) : x_r;
   end

endmodule

// File: rtl/ema_filter_core.sv
// EMA filter core: valid/ready FSM around ema_step_dp, one sample in flight, LUT address latch.
// Define EMA_ROUND_EN for round-half-up instead of floor on the coefficient shift.
module ema_filter_core
   import ema_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  alpha_sel,
   input  logic              flush,
   output logic [SEL_W-1:0]  lut_addr,
   input  logic [COEF_W-1:0] lut_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              busy
);

   ema_state_t        state;
   ema_state_t        state_n;
   ema_ctrl_t         ctrl_c;
   logic              accept_c;
   logic              primed;
   logic [DATA_W-1:0] y_acc_c;
   logic              unused_coef_hi;

   assign unused_coef_hi = ^lut_data[COEF_W-1:ALPHA_FRAC];

   assign s_ready  = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);
   assign accept_c = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      ctrl_c  = '0;
      case (state)
         IDLE: begin
            if (accept_c) begin
               ctrl_c.load_x = 1'b1;
               state_n       = SUB;
            end
         end
         SUB: begin
            ctrl_c.sub_en = 1'b1;
            state_n       = MUL;
         end
         MUL: begin
            ctrl_c.mul_en = 1'b1;
            state_n       = ACC;
         end
         ACC: begin
            ctrl_c.acc_en = 1'b1;
            state_n       = OUT;
         end
         OUT: begin
            if (m_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output, LUT address and priming state; flush beats the ACC set of primed
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid  <= 1'b0;
         m_data   <= '0;
         lut_addr <= '0;
         primed   <= 1'b0;
      end else begin
         if (accept_c) begin
            lut_addr <= alpha_sel;
         end
         if (ctrl_c.acc_en) begin
            m_valid <= 1'b1;
            m_data  <= y_acc_c;
         end else if ((state == OUT) && m_ready) begin
            m_valid <= 1'b0;
         end
         if (flush) begin
            primed <= 1'b0;
         end else if (ctrl_c.acc_en) begin
            primed <= 1'b1;
         end
      end
   end

   ema_step_dp u_dp (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (ctrl_c),
      .primed  (primed),
      .s_data  (s_data),
      .coef    (lut_data[ALPHA_FRAC-1:0]),
      .y_acc_c (y_acc_c)
   );

endmodule

// File: tb/tb_ema_filter_core.sv
// Bench for ema_filter_core: vector table, hand-written flush/backpressure/reset sequences, random vs model.
module tb_ema_filter_core;

`ifdef EMA_ROUND_EN
   localparam int BIAS = 32;
`else
   localparam int BIAS = 0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [7:0]         alpha_sel = '0;
   logic               flush = 1'b0;
   logic [7:0]         lut_addr;
   logic [15:0]        lut_data;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [15:0]        s_data = '0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic signed [15:0] m_data;
   logic               busy;

   always #5 clk = ~clk;

   // Stand-in for ema_lut_alpha: coefficient = address >> 2
   assign lut_data = {8'h00, 2'b00, lut_addr[7:2]};

   ema_filter_core dut (
      .clk       (clk),
      .rst       (rst),
      .alpha_sel (alpha_sel),
      .flush     (flush),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit fl;
      int sel;
      int x;
      int exp;
   } vec_t;

   vec_t tbl[$];

   int  m_y;
   bit  m_primed;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   function automatic int floor64(input int v);
      if (v >= 0) return v / 64;
      return -((-v + 63) / 64);
   endfunction

   task automatic add(input bit fl, input int sel, input int x, input int exp);
      vec_t v;
      v.fl = fl; v.sel = sel; v.x = x; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic flush_idle();
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
   endtask

   // One sample through the core; fe = edge offset (from accept) of a flush pulse, -1 for none
   task automatic run_sample(input int x, input int sel, input int fe, input int hold,
                             input int exp, input string name);
      int lat;
      int w;
      w = 0;
      while (!s_ready && w < 8) begin
         @(posedge clk); @(negedge clk);
         w++;
      end
      chk({name, "_sready"}, int'(s_ready), 1);
      s_valid   = 1'b1;
      s_data    = 16'(x);
      alpha_sel = 8'(sel);
      flush     = (fe == 0);
      @(posedge clk); @(negedge clk);
      s_valid   = 1'b0;
      s_data    = '0;
      alpha_sel = ~alpha_sel;
      lat       = 1;
      flush     = (fe == 1);
      while (!m_valid && lat < 12) begin
         @(posedge clk); @(negedge clk);
         lat++;
         flush = (fe == lat);
      end
      flush = 1'b0;
      chk({name, "_latency"}, lat, 4);
      chk({name, "_data"}, int'(m_data), exp);
      if (hold > 0) begin
         s_valid = 1'b1;
         s_data  = 16'(~x);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk({name, "_hold_valid"}, int'(m_valid), 1);
            chk({name, "_hold_data"}, int'(m_data), exp);
            chk({name, "_hold_sready"}, int'(s_ready), 0);
         end
      end
      m_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'b0;
      chk({name, "_mvalid_clr"}, int'(m_valid), 0);
      if (hold > 0) begin
         @(posedge clk); @(negedge clk);
         chk({name, "_no_accept"}, int'(busy), 0);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mvalid", int'(m_valid), 0);
      chk("rst_mdata", int'(m_data), 0);
      chk("rst_lut_addr", int'(lut_addr), 0);
      chk("rst_sready", int'(s_ready), 0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rel_sready", int'(s_ready), 1);
      chk("rel_busy", int'(busy), 0);

      // Directed vectors: prime/step, negative, max coefficient, rounding, coef=0, extremes
      add(1'b1, 128, 0, 0);
      add(1'b0, 128, 1000, 500);
      add(1'b0, 128, 1000, 750);
      add(1'b1, 128, 200, 200);
      add(1'b1, 128, 0, 0);
      add(1'b0, 128, -1000, -500);
      add(1'b1, 128, 0, 0);
      add(1'b0, 255, 64, 63);
      add(1'b1, 0, 0, 0);
      add(1'b0, 4, 40, (BIAS != 0) ? 1 : 0);
      add(1'b0, 2, 5000, (BIAS != 0) ? 1 : 0);
      add(1'b1, 4, 0, 0);
      add(1'b0, 4, -40, -1);
      add(1'b1, 255, -32768, -32768);
      add(1'b0, 255, 32767, 31743);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].fl) flush_idle();
         run_sample(tbl[i].x, tbl[i].sel, -1, 0, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Flush mid-flight re-primes; flush on the ACC edge keeps the result but drops history
      flush_idle();
      run_sample(0, 128, -1, 0, 0, "mf_prime");
      run_sample(1000, 128, 1, 0, 1000, "mf_flush_sub");
      run_sample(0, 128, -1, 0, 500, "mf_step");
      run_sample(100, 128, 3, 0, 300, "mf_flush_acc");
      run_sample(-50, 128, -1, 0, -50, "mf_reprime");

      // Backpressure: output held five cycles, pending input not taken
      run_sample(950, 128, -1, 5, 450, "bp");

      // Reset while in MUL drops the sample
      s_valid   = 1'b1;
      s_data    = 16'(300);
      alpha_sel = 8'd128;
      @(posedge clk); @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("mul_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("mulrst_mvalid", int'(m_valid), 0);
      chk("mulrst_mdata", int'(m_data), 0);
      chk("mulrst_lut_addr", int'(lut_addr), 0);
      chk("mulrst_busy", int'(busy), 0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (m_valid) seen++;
         end
         chk("mulrst_no_output", seen, 0);
      end
      run_sample(-7, 128, -1, 0, -7, "post_rst");
      run_sample(1, 128, -1, 0, -3, "post_rst_step");

      // Random samples against the model
      flush_idle();
      m_primed = 1'b0;
      m_y      = 0;
      for (int i = 0; i < 40; i++) begin
         logic signed [15:0] xs;
         int x;
         int sel;
         int fe;
         int e;
         xs  = 16'($urandom);
         x   = int'(xs);
         sel = int'($urandom_range(255, 0));
         fe  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
         if (fe >= 0 && fe < 3) m_primed = 1'b0;
         e = m_primed ? m_y + floor64((x - m_y) * (sel / 4) + BIAS) : x;
         m_y      = e;
         m_primed = 1'b1;
         if (fe == 3) m_primed = 1'b0;
         run_sample(x, sel, fe, 0, e, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
